// File: rtl/demux_1to8_128bit_buf_if.sv
// Bundle of the producer-side and consumer-side signals for the 1-to-8 buffered demux.
// The master drives words in and pops words out; the slave is the demux itself.
interface demux_1to8_128bit_buf_if #(
  parameter int unsigned DATA_W = 128
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic [2:0]          in_sel;
  logic                in_ready;
  logic                auto_mode;
  logic                ptr_clr;
  logic [8*DATA_W-1:0] out_data;
  logic [7:0]          out_valid;
  logic [7:0]          out_ready;
  logic [2:0]          ptr;
  logic [3:0]          occupancy;

  modport master (
    output in_data,
    output in_valid,
    output in_sel,
    output auto_mode,
    output ptr_clr,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  ptr,
    input  occupancy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sel,
    input  auto_mode,
    input  ptr_clr,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output ptr,
    output occupancy
  );
endinterface

// File: rtl/demux_1to8_128bit_buf.sv
// 1-to-8 demultiplexer with a one-entry buffer per output channel, manual or
// round-robin destination selection, and a registered occupancy count.
module demux_1to8_128bit_buf #(
  parameter int unsigned DATA_W = 128
) (
  input logic                       clk,
  input logic                       rst_n,
  demux_1to8_128bit_buf_if.slave    bus
);
  localparam int unsigned NumCh = 8;

  logic [2:0]                         dst;
  logic [NumCh-1:0]                   dst_oh;
  logic                               in_ready;
  logic                               accept;
  logic [NumCh-1:0]                   pop;

  logic [NumCh-1:0]                   valid_q, valid_d;
  logic [NumCh-1:0][DATA_W-1:0]       data_q, data_d;
  logic [2:0]                         ptr_q, ptr_d;
  logic [3:0]                         occ_q, occ_d;

  // Destination and acceptance: a full channel may still accept if it pops on the same edge.
  always_comb begin
    dst      = bus.auto_mode ? ptr_q : bus.in_sel;
    dst_oh   = NumCh'(1) << dst;
    in_ready = ~valid_q[dst] | bus.out_ready[dst];
    accept   = bus.in_valid & in_ready;
    pop      = valid_q & bus.out_ready;
  end

  always_comb begin
    valid_d = (valid_q & ~pop) | (accept ? dst_oh : '0);
    data_d  = data_q;
    if (accept) begin
      data_d[dst] = bus.in_data;
    end
  end

  // Clear wins over the increment; the 3-bit add wraps 7 -> 0 on its own.
  always_comb begin
    ptr_d = ptr_q;
    if (bus.ptr_clr) begin
      ptr_d = 3'd0;
    end else if (accept && bus.auto_mode) begin
      ptr_d = ptr_q + 3'd1;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NumCh; i++) begin
      occ_d = occ_d + {3'b000, valid_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= 3'd0;
      occ_q   <= 4'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.ptr       = ptr_q;
  assign bus.occupancy = occ_q;

  occ_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q == 4'($countones(valid_q)));

endmodule

// File: tb/tb_demux_1to8_128bit_buf.sv
// Randomized and directed bench for demux_1to8_128bit_buf, checked against a
// per-channel array model of the buffer contents and the round-robin pointer.
module tb_demux_1to8_128bit_buf;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_1to8_128bit_buf_if #(.DATA_W(DW)) bus ();
  demux_1to8_128bit_buf #(.DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  bit            m_valid[8];
  logic [DW-1:0] m_data[8];
  int            m_ptr;

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int m_dst();
    return bus.auto_mode ? m_ptr : int'(bus.in_sel);
  endfunction

  function automatic logic m_ready();
    int d;
    d = m_dst();
    return !m_valid[d] || bus.out_ready[d];
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_valid[i];
    return r;
  endfunction

  function automatic logic [3:0] m_occ();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_valid[i]);
    return 4'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_ptr = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then step the DUT.
  task automatic tick();
    bit acc;
    int d;
    d   = m_dst();
    acc = bus.in_valid && m_ready();
    for (int i = 0; i < 8; i++) if (m_valid[i] && bus.out_ready[i]) m_valid[i] = 1'b0;
    if (acc) begin
      m_valid[d] = 1'b1;
      m_data[d]  = bus.in_data;
    end
    if (bus.ptr_clr) m_ptr = 0;
    else if (acc && bus.auto_mode) m_ptr = (m_ptr + 1) % 8;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_data   = '0;
    bus.auto_mode = 1'b0;
    bus.ptr_clr   = 1'b0;
    bus.out_ready = 8'h00;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'hFF;
    tick();
    bus.out_ready = 8'h00;
  endtask

  task automatic test_reset();
    logic [DW-1:0] w;
    w = rnd_word();
    idle_inputs();
    model_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd3;
    bus.in_data  = w;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL reset_valid: got %b want 00000000", bus.out_valid);
    end
    checks++;
    if (bus.occupancy !== 4'd0) begin
      errors++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy);
    end
    checks++;
    if (bus.ptr !== 3'd0) begin
      errors++; $display("FAIL reset_ptr: got %0d want 0", bus.ptr);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.out_data[i*DW +: DW] !== '0) begin
        errors++; $display("FAIL reset_data ch%0d: got %h want 0", i, bus.out_data[i*DW +: DW]);
      end
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic test_manual_route();
    logic [DW-1:0] w;
    w = 128'hDEAD_0000_0000_0000_0000_0000_0000_0005;
    bus.auto_mode = 1'b0;
    bus.in_sel    = 3'd5;
    bus.in_data   = w;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'b0010_0000) begin
      errors++; $display("FAIL route_valid: got %b want 00100000", bus.out_valid);
    end
    checks++;
    if (bus.out_data[5*DW +: DW] !== w) begin
      errors++; $display("FAIL route_data: got %h want %h", bus.out_data[5*DW +: DW], w);
    end
    checks++;
    if (bus.occupancy !== 4'd1) begin
      errors++; $display("FAIL route_occ: got %0d want 1", bus.occupancy);
    end
    drain();
    checks++;
    if (bus.out_valid !== 8'h00 || bus.out_data[5*DW +: DW] !== w) begin
      errors++;
      $display("FAIL pop_hold: got valid %b data %h want 00000000 %h",
               bus.out_valid, bus.out_data[5*DW +: DW], w);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w1, w2;
    w1 = rnd_word();
    w2 = rnd_word();
    bus.auto_mode = 1'b0;
    bus.in_sel    = 3'd2;
    bus.in_data   = w1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 8'h00;
    tick();
    bus.in_data = w2;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_data[2*DW +: DW] !== w1) begin
        errors++;
        $display("FAIL bp_stall cyc%0d: got ready %b data %h want 0 %h",
                 c, bus.in_ready, bus.out_data[2*DW +: DW], w1);
      end
      tick();
    end
    bus.out_ready = 8'b0000_0100;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    checks++;
    if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*DW +: DW] !== w2) begin
      errors++;
      $display("FAIL bp_passthru: got valid %b data %h want 1 %h",
               bus.out_valid[2], bus.out_data[2*DW +: DW], w2);
    end
    drain();
  endtask

  task automatic test_auto_wrap();
    logic [DW-1:0] w;
    logic [7:0]    expv;
    bus.ptr_clr = 1'b1;
    tick();
    bus.ptr_clr   = 1'b0;
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      w           = rnd_word();
      bus.in_data = w;
      #1;
      checks++;
      if (bus.ptr !== 3'(k % 8)) begin
        errors++; $display("FAIL wrap_ptr k%0d: got %0d want %0d", k, bus.ptr, k % 8);
      end
      tick();
      expv = 8'h01 << (k % 8);
      checks++;
      if (bus.out_valid !== expv || bus.out_data[(k % 8)*DW +: DW] !== w) begin
        errors++;
        $display("FAIL wrap_route k%0d: got valid %b data %h want %b %h",
                 k, bus.out_valid, bus.out_data[(k % 8)*DW +: DW], expv, w);
      end
    end
    checks++;
    if (bus.ptr !== 3'd1) begin
      errors++; $display("FAIL wrap_final_ptr: got %0d want 1", bus.ptr);
    end
    drain();
    bus.auto_mode = 1'b0;
  endtask

  task automatic test_auto_stall();
    logic [DW-1:0] w;
    bus.ptr_clr = 1'b1;
    tick();
    bus.ptr_clr   = 1'b0;
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      bus.in_data = rnd_word();
      tick();
    end
    drain();
    bus.auto_mode = 1'b0;
    bus.in_sel    = 3'd3;
    bus.in_valid  = 1'b1;
    bus.in_data   = rnd_word();
    tick();
    w             = rnd_word();
    bus.in_data   = w;
    bus.auto_mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.ptr !== 3'd3) begin
        errors++;
        $display("FAIL stall cyc%0d: got ready %b ptr %0d want 0 3", c, bus.in_ready, bus.ptr);
      end
      tick();
    end
    bus.out_ready = 8'b0000_1000;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    checks++;
    if (bus.ptr !== 3'd4 || bus.out_valid[3] !== 1'b1 || bus.out_data[3*DW +: DW] !== w) begin
      errors++;
      $display("FAIL stall_release: got ptr %0d valid %b data %h want 4 1 %h",
               bus.ptr, bus.out_valid[3], bus.out_data[3*DW +: DW], w);
    end
    drain();
    bus.auto_mode = 1'b0;
  endtask

  task automatic test_fill_drain();
    bus.auto_mode = 1'b0;
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_sel  = 3'(i);
      bus.in_data = rnd_word();
      tick();
    end
    bus.in_sel = 3'(($urandom % 8));
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 4'd8 || bus.out_valid !== 8'hFF) begin
      errors++;
      $display("FAIL fill: got occ %0d valid %b want 8 11111111", bus.occupancy, bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.out_data[i*DW +: DW] !== m_data[i]) begin
        errors++;
        $display("FAIL fill_data ch%0d: got %h want %h", i, bus.out_data[i*DW +: DW], m_data[i]);
      end
    end
    drain();
    checks++;
    if (bus.occupancy !== 4'd0 || bus.out_valid !== 8'h00) begin
      errors++;
      $display("FAIL drain: got occ %0d valid %b want 0 00000000", bus.occupancy, bus.out_valid);
    end
  endtask

  task automatic test_ptr_clr();
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    repeat (2) begin
      bus.in_data = rnd_word();
      tick();
    end
    bus.ptr_clr = 1'b1;
    bus.in_data = rnd_word();
    tick();
    bus.ptr_clr  = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.ptr !== 3'(m_ptr) || bus.out_valid !== m_vec()) begin
      errors++;
      $display("FAIL ptr_clr: got ptr %0d valid %b want %0d %b",
               bus.ptr, bus.out_valid, m_ptr, m_vec());
    end
    drain();
    bus.auto_mode = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 10) < 7;
      bus.in_sel    = 3'($urandom % 8);
      bus.in_data   = rnd_word();
      bus.out_ready = 8'($urandom);
      bus.ptr_clr   = ($urandom % 20) == 0;
      if (($urandom % 8) == 0) bus.auto_mode = ~bus.auto_mode;
      #1;
      checks++;
      if (bus.in_ready !== m_ready()) begin
        errors++; $display("FAIL rnd_ready cyc%0d: got %b want %b", c, bus.in_ready, m_ready());
      end
      tick();
      checks++;
      if (bus.out_valid !== m_vec() || bus.occupancy !== m_occ() || bus.ptr !== 3'(m_ptr)) begin
        errors++;
        $display("FAIL rnd_state cyc%0d: got valid %b occ %0d ptr %0d want %b %0d %0d",
                 c, bus.out_valid, bus.occupancy, bus.ptr, m_vec(), m_occ(), m_ptr);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bus.out_data[i*DW +: DW] !== m_data[i]) begin
          errors++;
          $display("FAIL rnd_data cyc%0d ch%0d: got %h want %h",
                   c, i, bus.out_data[i*DW +: DW], m_data[i]);
        end
      end
    end
    idle_inputs();
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] w;
    bus.ptr_clr = 1'b1;
    tick();
    bus.ptr_clr   = 1'b0;
    bus.auto_mode = 1'b1;
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    repeat (6) begin
      bus.in_data = rnd_word();
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 4'd6 || bus.ptr !== 3'd6) begin
      errors++; $display("FAIL pre_rst: got occ %0d ptr %0d want 6 6", bus.occupancy, bus.ptr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 8'h00 || bus.ptr !== 3'd0 || bus.occupancy !== 4'd0) begin
      errors++;
      $display("FAIL async_rst: got valid %b ptr %0d occ %0d want 00000000 0 0",
               bus.out_valid, bus.ptr, bus.occupancy);
    end
    model_reset();
    rst_n         = 1'b1;
    w             = rnd_word();
    bus.auto_mode = 1'b0;
    bus.in_sel    = 3'd7;
    bus.in_data   = w;
    bus.in_valid  = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'h80 || bus.out_data[7*DW +: DW] !== w || bus.out_data[0 +: DW] !== '0)
    begin
      errors++;
      $display("FAIL post_rst: got valid %b ch7 %h ch0 %h want 10000000 %h 0",
               bus.out_valid, bus.out_data[7*DW +: DW], bus.out_data[0 +: DW], w);
    end
  endtask

  initial begin
    test_reset();
    test_manual_route();
    test_backpressure();
    test_auto_wrap();
    test_auto_stall();
    test_fill_drain();
    test_ptr_clr();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to8_128bit_buf.md
DEMUX_1TO8_128BIT_BUF -- requirements
Module: demux_1to8_128bit_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of each data word.
REQ-002 SHALL have port clk  input  1  single clock for all state, rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_data  input  DATA_W  word to distribute.
REQ-005 SHALL have port in_valid  input  1  in_data/in_sel valid this cycle.
REQ-006 SHALL have port in_sel  input  3  destination channel, used when auto_mode=0.
REQ-007 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have port auto_mode  input  1  1 = destination from internal pointer, 0 = from in_sel.
REQ-009 SHALL have port ptr_clr  input  1  synchronous clear of the internal pointer.
REQ-010 SHALL have port out_data  output  8*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port out_valid  output  8  channel i holds an unconsumed word.
REQ-012 SHALL have port out_ready  input  8  consumer i takes its word this cycle.
REQ-013 SHALL have port ptr  output  3  current auto-mode pointer.
REQ-014 SHALL have port occupancy  output  4  number of set bits in out_valid, 0..8.

Function
REQ-015 Destination dst SHALL be ptr when auto_mode=1, else in_sel.
REQ-016 in_ready SHALL be combinational: ~out_valid[dst] | out_ready[dst]; it SHALL NOT depend on in_valid.
REQ-017 Accept SHALL occur on a cycle with in_valid & in_ready; at that edge channel dst loads in_data and out_valid[dst] goes 1 (latency 1 cycle, input to output).
REQ-018 Pop on channel i SHALL occur on a cycle with out_valid[i] & out_ready[i]; at that edge out_valid[i] goes 0 unless the same edge accepts into i.
REQ-019 Simultaneous pop and accept on the same channel SHALL leave out_valid[i]=1 with the new word (full-rate pass-through, no bubble).
REQ-020 Each channel SHALL be one-entry; a word SHALL NOT be overwritten while out_valid[i]=1 and out_ready[i]=0.
REQ-021 out_data[i] SHALL hold its value until the next accept into i; it SHALL NOT change on pop.
REQ-022 Channels SHALL be independent: pops on any channels and one accept SHALL all take effect on the same edge.
REQ-023 ptr SHALL increment by 1 on each accept while auto_mode=1, wrapping 7 -> 0; it SHALL NOT change when auto_mode=0.
REQ-024 ptr_clr=1 SHALL set ptr to 0 at the edge, overriding any increment on that edge; the accept itself still proceeds.
REQ-025 In auto_mode with the pointed channel full and not popping, in_ready SHALL be 0 and ptr SHALL hold (strict round-robin, no skipping).
REQ-026 occupancy SHALL be the registered count, consistent with out_valid every cycle.
REQ-027 Changing auto_mode or in_sel while in_valid=1 and in_ready=0 SHALL be legal; dst SHALL be re-evaluated each cycle.

Reset
REQ-028 On rst_n=0, asynchronously: out_valid=8'h00, occupancy=0, ptr=0, all out_data words 0.
REQ-029 in_ready during reset SHALL be 1 (derived from cleared out_valid); no accept SHALL be registered while rst_n=0.
REQ-030 Reset asserted mid-operation SHALL discard all held words; the first edge after release SHALL behave as from the empty state.

Verification
REQ-031 Manual route: auto_mode=0, in_sel=5, in_data=128'hDEAD...0005, one cycle valid -> next cycle out_valid=8'b0010_0000, channel 5 data matches, occupancy=1.
REQ-032 Backpressure: channel 2 full, out_ready[2]=0, in_sel=2, in_valid=1 -> in_ready=0 for 10 cycles, data unchanged; raise out_ready[2] -> same-edge pop+accept, out_valid[2] stays 1 with the new word.
REQ-033 Auto wrap: auto_mode=1, all out_ready=1, 9 back-to-back words -> channels 0..7 then 0, ptr sequence 0..7,0,1.
REQ-034 Auto stall: auto_mode=1, ptr=3, channel 3 full, out_ready=0 -> in_ready=0, ptr holds 3; pop channel 3 -> accept, ptr=4.
REQ-035 Fill and drain: 8 accepts with out_ready=0 -> occupancy=8, out_valid=8'hFF; pop all in one cycle -> occupancy=0 next cycle.
REQ-036 Reset mid-flight: occupancy=6, ptr=6, assert rst_n=0 asynchronously -> out_valid=0, ptr=0, occupancy=0 before the next clock edge.
